jtdd_snd_mix: RTL and testbench
===============================

JTDD_SND_MIX -- requirements
Module: jtdd_snd_mix

Interface
REQ-001 SHALL have parameter CH, default 2: number of mixed channels, legal 2..8.
REQ-002 SHALL have parameter WIN, default 16: signed width of each channel input.
REQ-003 SHALL have parameter WOUT, default 16: signed width of the mixed output.
REQ-004 SHALL have parameter LIMIT, default 1: 1 enables the automatic master-gain limiter, 0 fixes master gain at 1.0.
REQ-005 SHALL have parameter RECOVER, default 256: number of clean output samples before the limiter raises master gain one step.
REQ-006 SHALL have port clk, input, 1 bit: single clock, 48 MHz.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port cen, input, 1 bit: one-cycle strobe that requests a new output sample.
REQ-009 SHALL have port ch_snd, input, CH*WIN bits: packed signed channel samples, channel 0 in the LSBs.
REQ-010 SHALL have port ch_gain, input, CH*8 bits: packed unsigned per-channel gains in 4.4 format (8'h10 = 1.0).
REQ-011 SHALL have port ch_en, input, CH bits: per-channel enable; a disabled channel contributes 0.
REQ-012 SHALL have port sound, output, WOUT bits: signed mixed sample.
REQ-013 SHALL have port sample, output, 1 bit: one-cycle pulse marking each update of sound.
REQ-014 SHALL have port busy, output, 1 bit: high while a mix is in progress.
REQ-015 SHALL have port clip, output, 1 bit: sticky flag, set when any output saturates, cleared by rst.
REQ-016 SHALL have port mgain, output, 8 bits: current master gain in 4.4 format.

Function
REQ-017 SHALL run a state machine with states IDLE, ACC, SCALE and OUT.
REQ-018 In IDLE, cen=1 SHALL snapshot ch_snd, ch_gain and ch_en into internal registers, clear the accumulator and go to ACC.
REQ-019 ACC SHALL add ch_snd[i]*ch_gain[i] (signed x unsigned) to the accumulator for one channel i per clock, in order i=0..CH-1, and SHALL go to SCALE after channel CH-1.
REQ-020 The accumulator SHALL be WIN+9+clog2(CH) bits wide, so it never overflows internally.
REQ-021 SCALE SHALL multiply the accumulator by mgain, arithmetic-shift the product right by 8 (removing both 4.4 fractions), and saturate the result to the WOUT signed range.
REQ-022 OUT SHALL register sound, assert sample for exactly one cycle and return to IDLE.
REQ-023 Latency SHALL be fixed: with cen at cycle 0, sample SHALL be high at cycle CH+2.
REQ-024 busy SHALL be high from the cycle after the accepted cen through the sample cycle, inclusive.
REQ-025 A cen arriving while busy=1 SHALL be ignored and SHALL NOT disturb the mix in progress.
REQ-026 Input changes after the snapshot SHALL NOT affect the current sample.
REQ-027 On saturation, clip SHALL be set; clip SHALL stay set until rst.
REQ-028 With LIMIT=1, a saturated sample SHALL decrement mgain by 1, but mgain SHALL NOT go below 8'h08.
REQ-029 With LIMIT=1, a clean-sample counter SHALL reset to 0 on every saturated sample; when it reaches RECOVER, mgain SHALL increment by 1 (capped at 8'h10) and the counter SHALL reset to 0.
REQ-030 The limiter updates SHALL take effect starting with the next sample, never the current one.
REQ-031 With LIMIT=0, mgain SHALL remain 8'h10.

Reset
REQ-032 rst SHALL force: state=IDLE, sound=0, sample=0, busy=0, clip=0, mgain=8'h10, counter=0, accumulator=0.
REQ-033 rst asserted mid-mix SHALL abort the mix with no sample pulse; the first cen after rst is released SHALL be accepted.

Structure
REQ-034 A shared package jtdd_snd_pkg SHALL hold the state encoding, MGAIN_UNITY (8'h10), MGAIN_MIN (8'h08) and the 4.4 fraction width (4).
REQ-035 Saturation SHALL be implemented in a single sub-module jtdd_snd_sat, parameterised by input width and output width.
REQ-036 No multiplier SHALL be instantiated per channel; the design SHALL use one time-shared multiplier for ACC.

Verification
REQ-037 CH=2, inputs 1000 and -200, gains 8'h10, 8'h10, cen -> sound=800, sample at cycle 4, clip=0.
REQ-038 CH=4, all inputs 16'h7000, gains 8'h10 -> sound=16'h7fff, clip=1, mgain drops to 8'h0f on the next sample.
REQ-039 LIMIT=1, RECOVER=4, mgain at 8'h0e, then 8 clean samples -> mgain steps to 8'h0f, then 8'h10, and holds at 8'h10.
REQ-040 cen issued again at cycle 1 of a mix -> exactly one sample pulse; output equals the first snapshot's mix.
REQ-041 ch_en=2'b10 with inputs 5000 and 300 -> sound=300; rst at cycle 2 of a mix -> no sample pulse, all outputs at their reset values.
REQ-042 Negative full scale: CH=2, inputs -32768 and -32768 -> sound=-32768, clip=1.

Source files
------------

// File: rtl/jtdd_snd_pkg.sv
// Shared definitions for the sound mixer.
//   state_t      : mixer sequencer states
//   MGAIN_UNITY  : master gain of 1.0 in 4.4 format
//   MGAIN_MIN    : lowest master gain the limiter may reach (0.5)
//   FRAC_W       : fraction bits of every 4.4 gain value
package jtdd_snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  localparam logic [7:0] MGAIN_UNITY = 8'h10;
  localparam logic [7:0] MGAIN_MIN   = 8'h08;
  localparam int         FRAC_W      = 4;

endpackage

// File: rtl/jtdd_snd_sat.sv
// Signed saturation from WI bits down to WO bits (WI > WO).
//   din  : signed input value
//   dout : din clamped to the signed WO-bit range
//   sat  : high when clamping occurred
module jtdd_snd_sat #(
  parameter int WI = 36,
  parameter int WO = 16
) (
  input  logic signed [WI-1:0] din,
  output logic signed [WO-1:0] dout,
  output logic                 sat
);

  // The value fits when every bit above the output sign bit equals the sign.
  always_comb begin
    sat = (din[WI-1:WO-1] != {(WI-WO+1){din[WI-1]}});
    if (sat) begin
      dout = din[WI-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
    end else begin
      dout = din[WO-1:0];
    end
  end

endmodule

// File: rtl/jtdd_snd_mix.sv
// Multi-channel sound mixer with per-channel gain and an automatic
// master-gain limiter. One time-shared multiplier accumulates one channel
// per clock, then the sum is scaled by the master gain and saturated.
//   clk, rst : clock and synchronous active-high reset
//   cen      : request a new output sample (ignored while busy)
//   ch_snd   : packed signed channel samples, channel 0 in the LSBs
//   ch_gain  : packed unsigned 4.4 per-channel gains
//   ch_en    : per-channel enable
//   sound    : signed mixed sample
//   sample   : one-cycle pulse on each update of sound
//   busy     : high while a mix is in progress
//   clip     : sticky saturation flag
//   mgain    : current 4.4 master gain
module jtdd_snd_mix
  import jtdd_snd_pkg::*;
#(
  parameter int CH      = 2,
  parameter int WIN     = 16,
  parameter int WOUT    = 16,
  parameter int LIMIT   = 1,
  parameter int RECOVER = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cen,
  input  logic [CH*WIN-1:0]      ch_snd,
  input  logic [CH*8-1:0]        ch_gain,
  input  logic [CH-1:0]          ch_en,
  output logic signed [WOUT-1:0] sound,
  output logic                   sample,
  output logic                   busy,
  output logic                   clip,
  output logic [7:0]             mgain
);

  localparam int CHW   = $clog2(CH);
  localparam int WACC  = WIN + 9 + CHW;
  localparam int WPROD = WACC + 9;
  localparam int SHIFT = 2 * FRAC_W;
  localparam int CNTW  = $clog2(RECOVER + 1);

  state_t                 state_reg, state_next;
  logic [CHW-1:0]         idx_reg;
  logic signed [WIN-1:0]  snd_reg  [CH];
  logic [7:0]             gain_reg [CH];
  logic signed [WIN-1:0]  in_snd   [CH];
  logic [7:0]             in_gain  [CH];
  logic signed [WACC-1:0] acc_reg;
  logic signed [WOUT-1:0] sound_reg;
  logic                   sample_reg;
  logic                   clip_reg;
  logic [7:0]             mgain_reg;
  logic [CNTW-1:0]        cnt_reg;

  logic                   take;
  logic                   last_ch;
  logic signed [WIN-1:0]  cur_snd;
  logic [7:0]             cur_gain;
  logic signed [WIN+8:0]  ch_prod;
  logic signed [WACC-1:0] ch_term;
  logic signed [WPROD-1:0] scaled;
  logic signed [WPROD-1:0] shifted;
  logic signed [WOUT-1:0] sat_out;
  logic                   sat_hit;

  // Disabled channels are captured with a zero gain so they add nothing.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_unpack
      assign in_snd[gi]  = ch_snd[gi*WIN +: WIN];
      assign in_gain[gi] = ch_en[gi] ? ch_gain[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign take    = (state_reg == ST_IDLE) && cen;
  assign last_ch = (idx_reg == CHW'(CH-1));

  // Shared channel multiplier: signed sample x unsigned gain.
  assign cur_snd  = snd_reg[idx_reg];
  assign cur_gain = gain_reg[idx_reg];
  assign ch_prod  = $signed({{9{cur_snd[WIN-1]}}, cur_snd}) *
                    $signed({{(WIN+1){1'b0}}, cur_gain});
  assign ch_term  = {{CHW{ch_prod[WIN+8]}}, ch_prod};

  // Master gain scaling; the shift drops both 4.4 fractions.
  assign scaled  = $signed({{9{acc_reg[WACC-1]}}, acc_reg}) *
                   $signed({{(WACC+1){1'b0}}, mgain_reg});
  assign shifted = scaled >>> SHIFT;

  jtdd_snd_sat #(
    .WI (WPROD),
    .WO (WOUT)
  ) u_sat (
    .din  (shifted),
    .dout (sat_out),
    .sat  (sat_hit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (cen) state_next = ST_ACC;
      ST_ACC:   if (last_ch) state_next = ST_SCALE;
      ST_SCALE: state_next = ST_OUT;
      ST_OUT:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_reg != ST_IDLE);
  end

  // Snapshot registers need no reset: they are always loaded before use.
  always_ff @(posedge clk) begin
    if (take) begin
      for (int i = 0; i < CH; i++) begin
        snd_reg[i]  <= in_snd[i];
        gain_reg[i] <= in_gain[i];
      end
    end
  end

  // Datapath, output registers and limiter
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg    <= '0;
      acc_reg    <= '0;
      sound_reg  <= '0;
      sample_reg <= 1'b0;
      clip_reg   <= 1'b0;
      mgain_reg  <= MGAIN_UNITY;
      cnt_reg    <= '0;
    end else begin
      sample_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cen) begin
            acc_reg <= '0;
            idx_reg <= '0;
          end
        end
        ST_ACC: begin
          acc_reg <= acc_reg + ch_term;
          idx_reg <= idx_reg + CHW'(1);
        end
        ST_SCALE: begin
          // sound and sample land together, so sample is high in ST_OUT
          sound_reg  <= sat_out;
          sample_reg <= 1'b1;
          if (sat_hit) clip_reg <= 1'b1;
          // The gain change is registered here, after it was used above,
          // so it only affects the following sample.
          if (LIMIT != 0) begin
            if (sat_hit) begin
              cnt_reg <= '0;
              if (mgain_reg > MGAIN_MIN) mgain_reg <= mgain_reg - 8'd1;
            end else if (cnt_reg == CNTW'(RECOVER-1)) begin
              cnt_reg <= '0;
              if (mgain_reg < MGAIN_UNITY) mgain_reg <= mgain_reg + 8'd1;
            end else begin
              cnt_reg <= cnt_reg + CNTW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sound  = sound_reg;
  assign sample = sample_reg;
  assign clip   = clip_reg;
  assign mgain  = mgain_reg;

endmodule

// File: tb/tb_jtdd_snd_mix.sv
`timescale 1ns/1ps
module tb_jtdd_snd_mix;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Two-channel instance with a short recovery window
  logic               rst2, cen2;
  logic [31:0]        ch_snd2;
  logic [15:0]        ch_gain2;
  logic [1:0]         ch_en2;
  logic signed [15:0] sound2;
  logic               sample2, busy2, clip2;
  logic [7:0]         mgain2;

  // Four-channel instance with default recovery
  logic               rst4, cen4;
  logic [63:0]        ch_snd4;
  logic [31:0]        ch_gain4;
  logic [3:0]         ch_en4;
  logic signed [15:0] sound4;
  logic               sample4, busy4, clip4;
  logic [7:0]         mgain4;

  jtdd_snd_mix #(.CH(2), .WIN(16), .WOUT(16), .LIMIT(1), .RECOVER(4)) dut2 (
    .clk(clk), .rst(rst2), .cen(cen2), .ch_snd(ch_snd2), .ch_gain(ch_gain2),
    .ch_en(ch_en2), .sound(sound2), .sample(sample2), .busy(busy2),
    .clip(clip2), .mgain(mgain2)
  );

  jtdd_snd_mix #(.CH(4), .WIN(16), .WOUT(16), .LIMIT(1), .RECOVER(256)) dut4 (
    .clk(clk), .rst(rst4), .cen(cen4), .ch_snd(ch_snd4), .ch_gain(ch_gain4),
    .ch_en(ch_en4), .sound(sound4), .sample(sample4), .busy(busy4),
    .clip(clip4), .mgain(mgain4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic [7:0]         ga;
    logic [7:0]         gb;
    logic [1:0]         en;
    int                 exp_snd;
  } vec_t;

  vec_t vecs [11];

  // One mix on dut2. Inputs are scrambled right after the snapshot; with
  // recen, cen is raised again during cycle 1 of the mix.
  task automatic mix2(input logic [15:0] a, input logic [15:0] b,
                      input logic [7:0] ga, input logic [7:0] gb,
                      input logic [1:0] en, input bit recen,
                      output int snd, output int lat, output int extra,
                      output logic b1, output logic bafter);
    @(negedge clk);
    ch_snd2 = {b, a}; ch_gain2 = {gb, ga}; ch_en2 = en; cen2 = 1'b1;
    @(negedge clk);
    cen2 = recen;
    ch_snd2 = ~{b, a}; ch_gain2 = ~{gb, ga}; ch_en2 = ~en;
    b1  = busy2;
    lat = 1;
    while (!sample2 && lat < 20) begin
      @(negedge clk);
      cen2 = 1'b0;
      lat++;
    end
    cen2 = 1'b0;
    snd  = int'(sound2);
    @(negedge clk);
    bafter = busy2;
    extra  = int'(sample2);
    repeat (6) begin
      @(negedge clk);
      extra += int'(sample2);
    end
  endtask

  task automatic mix2_chk(input string name, input logic [15:0] a,
                          input logic [15:0] b, input logic [7:0] ga,
                          input logic [7:0] gb, input logic [1:0] en,
                          input bit recen, input int exp_snd,
                          input logic exp_clip, input logic [7:0] exp_mg);
    int snd, lat, extra;
    logic b1, bafter;
    mix2(a, b, ga, gb, en, recen, snd, lat, extra, b1, bafter);
    $display("mix2 %s: a=%0d b=%0d ga=%h gb=%h en=%b -> sound=%0d lat=%0d clip=%b mgain=%h",
             name, $signed(a), $signed(b), ga, gb, en, snd, lat, clip2, mgain2);
    chk({name, ".sound"}, snd, exp_snd);
    chk({name, ".latency"}, lat, 4);
    chk({name, ".busy_c1"}, b1, 1);
    chk({name, ".busy_after"}, bafter, 0);
    chk({name, ".extra_pulses"}, extra, 0);
    chk({name, ".clip"}, clip2, exp_clip);
    chk({name, ".mgain"}, mgain2, exp_mg);
  endtask

  task automatic mix4(input logic [15:0] v, output int snd, output int lat);
    @(negedge clk);
    ch_snd4 = {4{v}}; ch_gain4 = {4{8'h10}}; ch_en4 = 4'hf; cen4 = 1'b1;
    @(negedge clk);
    cen4 = 1'b0; ch_snd4 = '0;
    lat = 1;
    while (!sample4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    snd = int'(sound4);
    $display("mix4: in=%0d -> sound=%0d lat=%0d clip=%b mgain=%h",
             $signed(v), snd, lat, clip4, mgain4);
  endtask

  task automatic reset2();
    @(negedge clk); rst2 = 1'b1;
    @(negedge clk); rst2 = 1'b0;
  endtask

  initial begin
    int snd, lat, pulses;
    logic [7:0] emg;

    vecs[0]  = '{16'sd1000,   -16'sd200,  8'h10, 8'h10, 2'b11, 800};
    vecs[1]  = '{16'sd5000,   16'sd300,   8'h10, 8'h10, 2'b10, 300};
    vecs[2]  = '{16'sd5000,   16'sd300,   8'h10, 8'h10, 2'b01, 5000};
    vecs[3]  = '{16'sd100,    16'sd100,   8'h20, 8'h08, 2'b11, 250};
    vecs[4]  = '{-16'sd1000,  16'sd0,     8'h18, 8'h10, 2'b11, -1500};
    vecs[5]  = '{16'sd7,      16'sd0,     8'h01, 8'h00, 2'b11, 0};
    vecs[6]  = '{-16'sd7,     16'sd0,     8'h01, 8'h00, 2'b11, -1};
    vecs[7]  = '{16'sd1234,   16'sd4321,  8'h10, 8'h10, 2'b00, 0};
    vecs[8]  = '{16'sd16383,  16'sd16384, 8'h10, 8'h10, 2'b11, 32767};
    vecs[9]  = '{-16'sd16384, -16'sd16384, 8'h10, 8'h10, 2'b11, -32768};
    vecs[10] = '{16'sd2047,   -16'sd2048, 8'hff, 8'h00, 2'b11, 32624};

    rst2 = 1'b1; cen2 = 1'b0; ch_snd2 = '0; ch_gain2 = '0; ch_en2 = '0;
    rst4 = 1'b1; cen4 = 1'b0; ch_snd4 = '0; ch_gain4 = '0; ch_en4 = '0;
    repeat (3) @(negedge clk);
    rst2 = 1'b0; rst4 = 1'b0;
    @(negedge clk);

    chk("reset.sound", sound2, 0);
    chk("reset.sample", sample2, 0);
    chk("reset.busy", busy2, 0);
    chk("reset.clip", clip2, 0);
    chk("reset.mgain", mgain2, 8'h10);
    chk("reset4.mgain", mgain4, 8'h10);
    chk("reset4.busy", busy4, 0);

    for (int i = 0; i < 11; i++) begin
      mix2_chk($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ga,
               vecs[i].gb, vecs[i].en, 1'b0, vecs[i].exp_snd, 1'b0, 8'h10);
    end

    // Four channels at 0x7000 overflow; the gain drop shows on the next mix.
    mix4(16'h7000, snd, lat);
    chk("ch4_sat.sound", snd, 32767);
    chk("ch4_sat.latency", lat, 6);
    chk("ch4_sat.clip", clip4, 1);
    chk("ch4_sat.mgain", mgain4, 8'h0f);
    mix4(16'd1000, snd, lat);
    chk("ch4_next.sound", snd, 3750);
    chk("ch4_next.mgain", mgain4, 8'h0f);

    // A second cen during cycle 1 is ignored.
    mix2_chk("recen", 16'd1000, -16'sd200, 8'h10, 8'h10, 2'b11, 1'b1, 800, 1'b0, 8'h10);

    // Negative full scale
    reset2();
    mix2_chk("negfs", -16'sd32768, -16'sd32768, 8'h10, 8'h10, 2'b11, 1'b0,
             -32768, 1'b1, 8'h0f);
    reset2();
    chk("rst_clip", clip2, 0);
    chk("rst_mgain", mgain2, 8'h10);

    // Limiter: two saturations, then recovery in steps of RECOVER=4.
    mix2_chk("lim_sat1", 16'd30000, 16'd30000, 8'h10, 8'h10, 2'b11, 1'b0, 32767, 1'b1, 8'h0f);
    mix2_chk("lim_sat2", 16'd30000, 16'd30000, 8'h10, 8'h10, 2'b11, 1'b0, 32767, 1'b1, 8'h0e);
    for (int k = 0; k < 12; k++) begin
      int esnd;
      esnd = (k < 4) ? 700 : (k < 8) ? 750 : 800;
      emg  = (k < 3) ? 8'h0e : (k < 7) ? 8'h0f : 8'h10;
      mix2_chk($sformatf("recover%0d", k), 16'd1000, -16'sd200, 8'h10, 8'h10,
               2'b11, 1'b0, esnd, 1'b1, emg);
    end

    // Floor: repeated saturation stops at 0x08.
    for (int k = 1; k <= 10; k++) begin
      emg = (16 - k > 8) ? 8'(16 - k) : 8'h08;
      mix2_chk($sformatf("floor%0d", k), 16'd32767, 16'd32767, 8'hff, 8'hff,
               2'b11, 1'b0, 32767, 1'b1, emg);
    end

    // Reset at cycle 2 of a mix aborts it without a sample pulse.
    @(negedge clk);
    ch_snd2 = {16'd300, 16'd5000}; ch_gain2 = 16'h1010; ch_en2 = 2'b10; cen2 = 1'b1;
    @(negedge clk);
    cen2 = 1'b0;
    @(negedge clk);
    pulses = int'(sample2);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin
        chk("midrst.sound", sound2, 0);
        chk("midrst.clip", clip2, 0);
        chk("midrst.mgain", mgain2, 8'h10);
        chk("midrst.busy", busy2, 0);
      end
      pulses += int'(sample2);
      @(negedge clk);
    end
    $display("midrst: pulses=%0d sound=%0d clip=%b mgain=%h", pulses, sound2, clip2, mgain2);
    chk("midrst.pulses", pulses, 0);

    mix2_chk("after_rst", 16'd5000, 16'd300, 8'h10, 8'h10, 2'b10, 1'b0, 300, 1'b0, 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
